// File: rtl/biquad_pass_scheduler.sv
// rtl/biquad_pass_scheduler.sv - round-robin pass scheduler for a shared double-biquad bank
//
// Purpose:
//   Shares one double-biquad datapath between NUM_REQ requesters. Each pass
//   goes through four steps. A round-robin arbiter picks a requester. Its
//   coefficient/state bank is selected and a one-cycle start pulse is issued.
//   The block then waits for done_in or a timeout. Finally the pass is
//   retired with a per-requester done or error pulse.
//   Every output is registered.
//
// Ports:
//   clk_in        in   1        system clock, posedge
//   rst_in        in   1        synchronous reset, active high
//   req_in        in   NUM_REQ  per-requester pass request (level, sampled in IDLE only)
//   done_in       in   1        datapath completion, honoured in WAIT only
//   grant_out     out  NUM_REQ  one-hot owner of the datapath, 0 when free
//   bank_sel_out  out  SEL_W    index of the granted requester (holds after retire)
//   start_out     out  1        one-cycle pulse to the datapath valid_in
//   done_out      out  NUM_REQ  one-cycle pulse: pass for requester i completed
//   err_out       out  NUM_REQ  one-cycle pulse: pass for requester i timed out
//   busy_out      out  1        high in every state except IDLE

module biquad_pass_scheduler #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int SEL_W         = $clog2(NUM_REQ)
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [NUM_REQ-1:0] req_in,
  input  logic               done_in,
  output logic [NUM_REQ-1:0] grant_out,
  output logic [SEL_W-1:0]   bank_sel_out,
  output logic               start_out,
  output logic [NUM_REQ-1:0] done_out,
  output logic [NUM_REQ-1:0] err_out,
  output logic               busy_out
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_RETIRE = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [SEL_W-1:0]   rr_ptr;
  logic [SEL_W-1:0]   rr_ptr_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;

  logic [NUM_REQ-1:0] grant_nxt;
  logic [SEL_W-1:0]   sel_nxt;
  logic               start_nxt;
  logic [NUM_REQ-1:0] done_nxt;
  logic [NUM_REQ-1:0] err_nxt;
  logic               busy_nxt;

  logic               pick_valid;
  logic [SEL_W-1:0]   pick_idx;

  // Round-robin search starting just after the last owner. The loop walks
  // from the farthest offset down to the nearest, so the nearest asserted
  // request is the last assignment and wins without needing a break.
  always_comb begin : arbiter
    logic [SEL_W-1:0] cand;
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = SEL_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (req_in[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin : next_state
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    cnt_nxt    = cnt;
    grant_nxt  = grant_out;
    sel_nxt    = bank_sel_out;
    start_nxt  = 1'b0;
    done_nxt   = '0;
    err_nxt    = '0;

    case (state)
      S_IDLE: begin
        if (pick_valid) begin
          state_nxt           = S_ISSUE;
          grant_nxt           = '0;
          grant_nxt[pick_idx] = 1'b1;
          sel_nxt             = pick_idx;
          start_nxt           = 1'b1;
        end
      end
      S_ISSUE: begin
        // done_in is ignored here: the datapath cannot answer in the start cycle.
        state_nxt = S_WAIT;
        cnt_nxt   = '0;
      end
      S_WAIT: begin
        // Completion is checked first, so a done_in on the last allowed
        // cycle still counts as success.
        if (done_in) begin
          state_nxt = S_RETIRE;
          done_nxt  = grant_out;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = S_RETIRE;
          err_nxt   = grant_out;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_RETIRE: begin
        // Grant is dropped leaving RETIRE; bank_sel_out keeps the last owner.
        state_nxt  = S_IDLE;
        grant_nxt  = '0;
        rr_ptr_nxt = bank_sel_out;
        cnt_nxt    = '0;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= S_IDLE;
      rr_ptr       <= SEL_W'(NUM_REQ - 1);
      cnt          <= '0;
      grant_out    <= '0;
      bank_sel_out <= '0;
      start_out    <= 1'b0;
      done_out     <= '0;
      err_out      <= '0;
      busy_out     <= 1'b0;
    end else begin
      state        <= state_nxt;
      rr_ptr       <= rr_ptr_nxt;
      cnt          <= cnt_nxt;
      grant_out    <= grant_nxt;
      bank_sel_out <= sel_nxt;
      start_out    <= start_nxt;
      done_out     <= done_nxt;
      err_out      <= err_nxt;
      busy_out     <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_biquad_pass_scheduler.sv
// tb/tb_biquad_pass_scheduler.sv - scoreboard bench for biquad_pass_scheduler

module tb_biquad_pass_scheduler;

  localparam int N   = 3;
  localparam int TMO = 64;

  typedef struct {
    int cyc;
    int kind;  // 0 start, 1 done, 2 err
    int who;
  } ev_t;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       done = 1'b0;
  logic [2:0] req  = 3'b000;
  logic [2:0] grant;
  logic [2:0] done_o;
  logic [2:0] err_o;
  logic [1:0] sel;
  logic       start;
  logic       busy;

  int  cyc         = 0;
  int  vectors     = 0;
  int  miscompares = 0;
  int  model_ptr   = N - 1;
  int  done_seen [N];
  bit  mon_en      = 1'b0;
  ev_t exp_q [$];

  biquad_pass_scheduler #(
    .NUM_REQ(N),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .req_in(req),
    .done_in(done),
    .grant_out(grant),
    .bank_sel_out(sel),
    .start_out(start),
    .done_out(done_o),
    .err_out(err_o),
    .busy_out(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Round-robin rule: first asserted request after the last owner.
  function automatic int model_pick(input logic [2:0] m);
    for (int i = 1; i <= N; i++) begin
      if (m[(model_ptr + i) % N]) return (model_ptr + i) % N;
    end
    return -1;
  endfunction

  // Monitor: any start/done/err pulse must match the next expected event.
  ev_t        e;
  logic [12:0] xv;
  always @(negedge clk) begin
    if (mon_en && (start === 1'b1 || (done_o | err_o) != 3'b000)) begin
      for (int i = 0; i < N; i++) if (done_o[i]) done_seen[i]++;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {19'b0, start, done_o, err_o, grant, sel, busy}, 32'h0);
      end else begin
        e  = exp_q.pop_front();
        xv = {e.kind == 0,
              (e.kind == 1) ? 3'(1 << e.who) : 3'b000,
              (e.kind == 2) ? 3'(1 << e.who) : 3'b000,
              3'(1 << e.who), 2'(e.who), 1'b1};
        check("event_cycle", cyc, e.cyc);
        check("event_outputs", {19'b0, start, done_o, err_o, grant, sel, busy}, {19'b0, xv});
      end
    end
  end

  // One full pass, entered at a negedge with the DUT idle at the next edge.
  // lat: WAIT edge (1-based) on which done_in is high; tmo: never complete.
  task automatic run_pass(input logic [2:0] mask, input int lat, input bit tmo,
                          input bit glitch, input bit hold, input logic [2:0] mid);
    int w;
    int ts;
    w    = model_pick(mask);
    req  = mask;
    done = 1'($urandom_range(0, 1));  // ignored in IDLE
    ts   = cyc + 1;
    exp_q.push_back('{ts, 0, w});
    @(negedge clk);                   // ISSUE
    req  = mid;
    done = glitch;                    // ignored in ISSUE
    @(negedge clk);                   // WAIT, first WAIT edge next
    done = 1'b0;
    if (tmo) begin
      exp_q.push_back('{ts + 1 + TMO, 2, w});
      repeat (TMO) @(negedge clk);
    end else begin
      exp_q.push_back('{ts + 1 + lat, 1, w});
      repeat (lat - 1) @(negedge clk);
      done = 1'b1;
      @(negedge clk);
    end
    done      = hold && !tmo;         // held into RETIRE: ignored
    model_ptr = w;
    @(negedge clk);                   // back in IDLE
    done = 1'b0;
    check("idle_after_pass", {27'b0, grant, busy, start}, 32'h0);
    check("bank_sel_hold", {30'b0, sel}, w);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    @(negedge clk);
    check("reset_outputs", {19'b0, start, done_o, err_o, grant, sel, busy}, 32'h0);
    rst       = 1'b0;
    model_ptr = N - 1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) done_seen[i] = 0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {19'b0, start, done_o, err_o, grant, sel, busy}, 32'h0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Single pass for requester 0.
    run_pass(3'b001, 5, 1'b0, 1'b0, 1'b0, 3'b000);

    // All requesting: rotation 0,1,2,0,1,2 from a fresh pointer.
    reset_dut();
    for (int i = 0; i < N; i++) done_seen[i] = 0;
    for (int p = 0; p < 6; p++) run_pass(3'b111, 3, 1'b0, 1'b0, 1'b0, 3'b111);
    for (int i = 0; i < N; i++) check("fair_done_count", done_seen[i], 2);

    // Timeout, then completion exactly on the timeout cycle.
    run_pass(3'b010, 0, 1'b1, 1'b0, 1'b0, 3'b000);
    run_pass(3'b101, TMO, 1'b0, 1'b0, 1'b0, 3'b000);

    // Reset while requester 2 is in WAIT: silent abandon, pointer restarts.
    req = 3'b100;
    exp_q.push_back('{cyc + 1, 0, model_pick(3'b100)});
    @(negedge clk);
    req = 3'b000;
    repeat (4) @(negedge clk);
    reset_dut();
    run_pass(3'b111, 2, 1'b0, 1'b0, 1'b0, 3'b111);

    // Granted request dropped and another raised mid-pass.
    run_pass(3'b010, 4, 1'b0, 1'b0, 1'b0, 3'b100);
    run_pass(3'b100, 1, 1'b0, 1'b0, 1'b0, 3'b000);

    // Randomized passes.
    for (int p = 0; p < 20; p++) begin
      int gap;
      gap = $urandom_range(0, 2);
      req = 3'b000;
      repeat (gap) begin
        done = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      run_pass(3'($urandom_range(1, 7)), $urandom_range(1, 10),
               ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end

    req  = 3'b000;
    done = 1'b0;
    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
